// File: rtl/fft_pkg.sv
// Shared FFT constants: sample width, frame size, bank index width, bit-reversal helper.
// Imported by the frame loader and the FFT datapath.
package fft_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned NPT        = 8;
   localparam int unsigned BANK_IDX_W = 3;

   typedef enum logic {StFilling, StFull} bank_state_e;

   function automatic logic [BANK_IDX_W-1:0] bitrev3(input logic [BANK_IDX_W-1:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

endpackage

// File: rtl/frame_bank.sv
// One ping-pong bank: single write port, full flag FSM, parallel read of all slots.
module frame_bank
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W = fft_pkg::DATA_W,
   parameter int unsigned NPT    = fft_pkg::NPT
) (
   input  logic                  clk_1,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [BANK_IDX_W-1:0] wr_slot,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  set_full,
   input  logic                  clr_full,
   output logic                  full,
   output logic [NPT*DATA_W-1:0] frame
);

   bank_state_e           state_q, state_d;
   logic [NPT*DATA_W-1:0] data_q;

   // Sample storage carries no reset; contents are ignored until the bank is full.
   always_ff @(posedge clk_1) begin
      if (wr_en) begin
         data_q[int'(wr_slot)*DATA_W +: DATA_W] <= wr_data;
      end
   end

   always_ff @(posedge clk_1) begin
      if (rst) begin
         state_q <= StFilling;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFilling: if (set_full) state_d = StFull;
         StFull:    if (clr_full) state_d = StFilling;
      endcase
   end

   assign full  = (state_q == StFull);
   assign frame = data_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the 8-point FFT datapath.
// Define LOADER_BITREV_EN to store samples in bit-reversed slot order.
module fft_frame_loader
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W = fft_pkg::DATA_W,
   parameter int unsigned NPT    = fft_pkg::NPT
) (
   input  logic                  clk_1,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  flush,
   output logic [NPT*DATA_W-1:0] m_frame,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [2:0]            fill_level,
   output logic                  frame_id
);

   logic [BANK_IDX_W-1:0] wr_ptr_q, wr_ptr_d, wr_slot;
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic                  frame_id_q, frame_id_d;
   logic [1:0]            full;
   logic [NPT*DATA_W-1:0] bank_frame [2];
   logic                  accept, consume, last;

   always_ff @(posedge clk_1) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         frame_id_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         frame_id_q <= frame_id_d;
      end
   end

   always_comb begin
      s_ready = !full[wr_bank_q] && !flush;
      accept  = s_valid && s_ready;
      m_valid = full[rd_bank_q];
      consume = m_valid && m_ready;
      last    = (wr_ptr_q == BANK_IDX_W'(NPT - 1));
`ifdef LOADER_BITREV_EN
      wr_slot = bitrev3(wr_ptr_q);
`else
      wr_slot = wr_ptr_q;
`endif

      wr_ptr_d   = wr_ptr_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      frame_id_d = frame_id_q;
      // flush already masks accept through s_ready, so it only needs to rewind the pointer
      if (flush) begin
         wr_ptr_d = '0;
      end else if (accept) begin
         if (last) begin
            wr_ptr_d  = '0;
            wr_bank_d = !wr_bank_q;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
      if (consume) begin
         rd_bank_d  = !rd_bank_q;
         frame_id_d = !frame_id_q;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      frame_bank #(
         .DATA_W (DATA_W),
         .NPT    (NPT)
      ) u_bank (
         .clk_1    (clk_1),
         .rst      (rst),
         .wr_en    (accept && (wr_bank_q == 1'(b))),
         .wr_slot  (wr_slot),
         .wr_data  (s_data),
         .set_full (accept && last && (wr_bank_q == 1'(b))),
         .clr_full (consume && (rd_bank_q == 1'(b))),
         .full     (full[b]),
         .frame    (bank_frame[b])
      );
   end

   assign m_frame    = bank_frame[rd_bank_q];
   assign fill_level = wr_ptr_q;
   assign frame_id   = frame_id_q;

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width in bits (signed two's complement).
REQ-002 SHALL have parameter NPT, default 8, meaning samples per frame; only 8 is legal.
REQ-003 SHALL have port clk_1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port s_data, input, DATA_W bits: serial input sample.
REQ-006 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-007 SHALL have port s_ready, output, 1 bit: loader accepts a sample this cycle.
REQ-008 SHALL have port flush, input, 1 bit: discard the partially filled frame.
REQ-009 SHALL have port m_frame, output, NPT*DATA_W bits: parallel frame; sample k at bits [k*DATA_W +: DATA_W], matching FFT datapath inputs in1..in8.
REQ-010 SHALL have port m_valid, output, 1 bit: m_frame holds a complete frame.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream consumes the frame.
REQ-012 SHALL have port fill_level, output, 3 bits: samples held in the write bank.
REQ-013 SHALL have port frame_id, output, 1 bit: toggles once per frame consumed.

Function
REQ-014 SHALL hold two frame banks (ping-pong), each NPT x DATA_W registers, with per-bank full flag.
REQ-015 SHALL accept a sample when s_valid && s_ready, writing it to the write bank at wr_ptr and incrementing wr_ptr.
REQ-016 SHALL drive s_ready = !full[wr_bank] && !flush.
REQ-017 SHALL, on acceptance with wr_ptr==7, set full[wr_bank], wrap wr_ptr to 0, and toggle wr_bank.
REQ-018 SHALL drive m_valid = full[rd_bank] and m_frame = bank[rd_bank], both from registers, with no combinational path from s_* to m_*.
REQ-019 SHALL have a latency of one cycle: the 8th sample accepted at edge t yields m_valid=1 after edge t.
REQ-020 SHALL, on m_valid && m_ready, clear full[rd_bank], toggle rd_bank, and toggle frame_id.
REQ-021 SHALL, when a frame completes and another is consumed in the same cycle, perform both updates; no frame is lost or duplicated.
REQ-022 SHALL hold m_frame stable while m_valid=1 and m_ready=0.
REQ-023 SHALL, when both banks are full, hold s_ready=0 until a consume occurs; s_ready rises in the cycle after the consume.
REQ-024 SHALL, on flush, set wr_ptr to 0 and discard the partial samples, leaving full banks and rd_bank untouched; flush takes precedence over a same-cycle write.
REQ-025 SHALL drive fill_level = wr_ptr.
REQ-026 SHALL operate as a two-state FSM per bank: FILLING to FULL on the 8th write, FULL to FILLING on consume.

Reset
REQ-027 SHALL, on rst, clear wr_ptr, wr_bank, rd_bank, both full flags and frame_id to 0, giving m_valid=0, s_ready=1 and fill_level=0.
REQ-028 SHALL not reset bank data; m_frame is don't-care while m_valid=0.
REQ-029 SHALL let rst mid-frame or mid-stall discard all frames, with a clean restart on the next cycle.

Configuration
REQ-030 SHALL, when LOADER_BITREV_EN is defined, store sample index i at bank slot bitrev3(i) (0,4,2,6,1,5,3,7), so m_frame is bit-reversed.
REQ-031 SHALL, when LOADER_BITREV_EN is undefined, store sample i at slot i (natural order); all other behaviour is identical.

Structure
REQ-032 SHALL take DATA_W, NPT, the bank-index width and the bitrev3 function from package fft_pkg, shared with the datapath.
REQ-033 SHALL implement a single sub-module, frame_bank (one bank: write port, full flag, parallel read), instantiated twice.

Verification
REQ-034 SHALL be verified with a single frame: stream 1..8 with s_valid held high and m_ready=0 -> m_valid rises one cycle after sample 8; m_frame slots 0..7 = 1..8 (bitrev: 1,5,3,7,2,6,4,8).
REQ-035 SHALL be verified with backpressure: stream 24 samples with m_ready=0 -> s_ready drops after sample 16; pulse m_ready -> frame 1..8 is consumed, s_ready returns, samples 17..24 are accepted.
REQ-036 SHALL be verified with simultaneous fill and consume: the 8th sample of frame B and a consume of frame A on the same edge -> m_valid stays 1, m_frame switches to B, frame_id toggles.
REQ-037 SHALL be verified with flush: write 3 samples, assert flush with s_valid=1 -> fill_level=0 and the sample is dropped; the next 8 samples form a complete frame.
REQ-038 SHALL be verified with reset: rst with one bank full and fill_level=5 -> next cycle m_valid=0, s_ready=1, fill_level=0, frame_id=0.
REQ-039 SHALL be verified with random s_valid/m_ready over 1000 frames -> output frames equal input frames in order, with none lost or duplicated.
